alu_rs_param: RTL and testbench

Parametrised ALU reservation station for the Tomasulo core, the successor to the fixed 4-entry add station. It holds CalcOp, CalcImmOp, LUI and AUIPC micro-ops until their operands arrive, and snoops N_CDB result buses. It issues the oldest ready entry to an internal ALU and presents the result through a one-slot output buffer with a valid/ready handshake to the CDB arbiter. Flush and reset are supported.

---
 rtl/alu_rs_pkg.sv | 37 +++
 rtl/alu_rs_exec.sv | 45 ++++
 rtl/alu_rs_param.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_rs_param.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared opcode/funct3 constants and the reservation-station entry layout
// for the ALU reservation station (default 32-bit data, 6-bit ROB tag).
package alu_rs_pkg;

  localparam logic [6:0] CALC_OP     = 7'b0110011;
  localparam logic [6:0] CALC_IMM_OP = 7'b0010011;
  localparam logic [6:0] LUI_OP      = 7'b0110111;
  localparam logic [6:0] AUIPC_OP    = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int RS_XLEN  = 32;
  localparam int RS_TAG_W = 6;

  // Default-width entry; the station mirrors this layout at its own XLEN/TAG_W.
  typedef struct packed {
    logic                valid;
    logic [RS_TAG_W-1:0] rob;
    logic [6:0]          op;
    logic [2:0]          sub;
    logic                flag;
    logic [RS_XLEN-1:0]  data1;
    logic [RS_XLEN-1:0]  data2;
    logic                q1_busy;
    logic [RS_TAG_W-1:0] q1;
    logic                q2_busy;
    logic [RS_TAG_W-1:0] q2;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_exec.sv
// Combinational integer ALU for the reservation station: CalcOp/CalcImmOp
// by funct3, LUI/AUIPC pass data2 through, anything else yields zero.
module alu_rs_exec
  import alu_rs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      i_op,
  input  logic [2:0]      i_sub,
  input  logic            i_flag,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_sh;

  always_comb begin
    w_sh     = i_b[SHW-1:0];
    o_result = '0;
    case (i_op)
      CALC_OP, CALC_IMM_OP: begin
        case (i_sub)
          F3_ADD:  o_result = (i_flag && i_op == CALC_OP) ? i_a - i_b : i_a + i_b;
          F3_SLL:  o_result = i_a << w_sh;
          F3_SLT:  o_result = XLEN'($signed(i_a) < $signed(i_b));
          F3_SLTU: o_result = XLEN'(i_a < i_b);
          F3_XOR:  o_result = i_a ^ i_b;
          F3_SRL: begin
            // kept as if/else so the arithmetic shift stays in signed context
            if (i_flag) o_result = $signed(i_a) >>> w_sh;
            else        o_result = i_a >> w_sh;
          end
          F3_OR:   o_result = i_a | i_b;
          F3_AND:  o_result = i_a & i_b;
          default: o_result = '0;
        endcase
      end
      LUI_OP, AUIPC_OP: o_result = i_b;
      default:          o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rs_param.sv
// Parametrised ALU reservation station: N_CDB snoop, oldest-ready issue via
// age matrix, one-slot output buffer. Option: ALU_RS_WAKE_BYPASS_EN.
module alu_rs_param
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int N_CDB = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [TAG_W-1:0]           disp_rob,
  input  logic [6:0]                 disp_op,
  input  logic [2:0]                 disp_sub,
  input  logic                       disp_flag,
  input  logic [XLEN-1:0]            disp_data1,
  input  logic [XLEN-1:0]            disp_data2,
  input  logic                       disp_q1_busy,
  input  logic                       disp_q2_busy,
  input  logic [TAG_W-1:0]           disp_q1,
  input  logic [TAG_W-1:0]           disp_q2,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]     cdb_rob,
  input  logic [N_CDB*XLEN-1:0]      cdb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_rob,
  output logic [XLEN-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0] free_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob;
    logic [6:0]       op;
    logic [2:0]       sub;
    logic             flag;
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic             q1_busy;
    logic [TAG_W-1:0] q1;
    logic             q2_busy;
    logic [TAG_W-1:0] q2;
  } entry_t;

  entry_t           r_ent     [DEPTH];
  entry_t           w_nxt     [DEPTH];
  logic [DEPTH-1:0] r_age     [DEPTH];
  logic [DEPTH-1:0] w_age_nxt [DEPTH];
  logic             r_out_valid;
  logic [TAG_W-1:0] r_out_rob;
  logic [XLEN-1:0]  r_out_data;

  logic [CW-1:0]    w_free;
  logic [IW-1:0]    w_alloc;
  logic             w_disp_ready, w_disp;
  logic             w_d_b1, w_d_b2, w_d_hit1, w_d_hit2;
  logic [XLEN-1:0]  w_d_data1, w_d_data2;
  logic [DEPTH-1:0] w_wake1, w_wake2, w_ready, w_sel;
  logic [XLEN-1:0]  w_wdata1 [DEPTH];
  logic [XLEN-1:0]  w_wdata2 [DEPTH];
  logic [XLEN-1:0]  w_opa    [DEPTH];
  logic [XLEN-1:0]  w_opb    [DEPTH];
  logic             w_issue;
  logic [6:0]       w_x_op;
  logic [2:0]       w_x_sub;
  logic             w_x_flag;
  logic [XLEN-1:0]  w_x_a, w_x_b, w_x_res;
  logic [TAG_W-1:0] w_x_rob;

  always_comb begin
    w_free  = '0;
    w_alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_ent[i].valid) begin
        w_free  = w_free + CW'(1);
        w_alloc = IW'(i);
      end
    end
    w_disp_ready = (w_free != '0);
    w_disp       = disp_valid && w_disp_ready && !flush;
  end

  // Immediate forms never wait on rs2; LUI/AUIPC wait on nothing.
  always_comb begin
    w_d_b1    = disp_q1_busy && !(disp_op == LUI_OP || disp_op == AUIPC_OP);
    w_d_b2    = disp_q2_busy && !(disp_op == CALC_IMM_OP || disp_op == LUI_OP ||
                                  disp_op == AUIPC_OP);
    w_d_hit1  = 1'b0;
    w_d_hit2  = 1'b0;
    w_d_data1 = disp_data1;
    w_d_data2 = disp_data2;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (w_d_b1 && cdb_valid[k] && cdb_rob[k*TAG_W +: TAG_W] == disp_q1) begin
        w_d_hit1  = 1'b1;
        w_d_data1 = cdb_data[k*XLEN +: XLEN];
      end
      if (w_d_b2 && cdb_valid[k] && cdb_rob[k*TAG_W +: TAG_W] == disp_q2) begin
        w_d_hit2  = 1'b1;
        w_d_data2 = cdb_data[k*XLEN +: XLEN];
      end
    end
  end

  // Descending scan so the lowest matching channel is the one kept.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wake1[i]  = 1'b0;
      w_wake2[i]  = 1'b0;
      w_wdata1[i] = '0;
      w_wdata2[i] = '0;
      for (int k = N_CDB - 1; k >= 0; k--) begin
        if (r_ent[i].valid && r_ent[i].q1_busy && cdb_valid[k] &&
            cdb_rob[k*TAG_W +: TAG_W] == r_ent[i].q1) begin
          w_wake1[i]  = 1'b1;
          w_wdata1[i] = cdb_data[k*XLEN +: XLEN];
        end
        if (r_ent[i].valid && r_ent[i].q2_busy && cdb_valid[k] &&
            cdb_rob[k*TAG_W +: TAG_W] == r_ent[i].q2) begin
          w_wake2[i]  = 1'b1;
          w_wdata2[i] = cdb_data[k*XLEN +: XLEN];
        end
      end
      w_opa[i] = w_wake1[i] ? w_wdata1[i] : r_ent[i].data1;
      w_opb[i] = w_wake2[i] ? w_wdata2[i] : r_ent[i].data2;
`ifdef ALU_RS_WAKE_BYPASS_EN
      w_ready[i] = r_ent[i].valid && (!r_ent[i].q1_busy || w_wake1[i]) &&
                   (!r_ent[i].q2_busy || w_wake2[i]);
`else
      w_ready[i] = r_ent[i].valid && !r_ent[i].q1_busy && !r_ent[i].q2_busy;
`endif
    end
  end

  // r_age[j][i] set means entry j was dispatched before entry i.
  always_comb begin
    w_x_op   = '0;
    w_x_sub  = '0;
    w_x_flag = 1'b0;
    w_x_a    = '0;
    w_x_b    = '0;
    w_x_rob  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && w_ready[j] && r_age[j][i]) w_sel[i] = 1'b0;
      end
      if (w_sel[i]) begin
        w_x_op   = r_ent[i].op;
        w_x_sub  = r_ent[i].sub;
        w_x_flag = r_ent[i].flag;
        w_x_a    = w_opa[i];
        w_x_b    = w_opb[i];
        w_x_rob  = r_ent[i].rob;
      end
    end
    w_issue = (|w_ready) && (!r_out_valid || out_ready);
  end

  alu_rs_exec #(.XLEN(XLEN)) u_exec (
    .i_op     (w_x_op),
    .i_sub    (w_x_sub),
    .i_flag   (w_x_flag),
    .i_a      (w_x_a),
    .i_b      (w_x_b),
    .o_result (w_x_res)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i]     = r_ent[i];
      w_age_nxt[i] = r_age[i];
      if (w_issue && w_sel[i]) begin
        w_nxt[i].valid = 1'b0;
      end else begin
        if (w_wake1[i]) begin
          w_nxt[i].q1_busy = 1'b0;
          w_nxt[i].data1   = w_wdata1[i];
        end
        if (w_wake2[i]) begin
          w_nxt[i].q2_busy = 1'b0;
          w_nxt[i].data2   = w_wdata2[i];
        end
      end
    end
    if (w_disp) begin
      w_nxt[w_alloc].valid   = 1'b1;
      w_nxt[w_alloc].rob     = disp_rob;
      w_nxt[w_alloc].op      = disp_op;
      w_nxt[w_alloc].sub     = disp_sub;
      w_nxt[w_alloc].flag    = disp_flag;
      w_nxt[w_alloc].data1   = w_d_data1;
      w_nxt[w_alloc].data2   = w_d_data2;
      w_nxt[w_alloc].q1_busy = w_d_b1 && !w_d_hit1;
      w_nxt[w_alloc].q1      = disp_q1;
      w_nxt[w_alloc].q2_busy = w_d_b2 && !w_d_hit2;
      w_nxt[w_alloc].q2      = disp_q2;
      for (int j = 0; j < DEPTH; j++) begin
        w_age_nxt[w_alloc][j] = 1'b0;
        if (j != int'(w_alloc)) w_age_nxt[j][w_alloc] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
        r_age[i] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_rob   <= '0;
      r_out_data  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_ent <= w_nxt;
      r_age <= w_age_nxt;
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_rob   <= w_x_rob;
        r_out_data  <= w_x_res;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign disp_ready = w_disp_ready;
  assign free_count = w_free;
  assign out_valid  = r_out_valid;
  assign out_rob    = r_out_rob;
  assign out_data   = r_out_data;

endmodule

// File: tb/tb_alu_rs_param.sv
// Directed self-checking bench for alu_rs_param (default parameters).
module tb_alu_rs_param;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int N_CDB = 2;
`ifdef ALU_RS_WAKE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [6:0] CALC  = 7'b0110011;
  localparam logic [6:0] CIMM  = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BADOP = 7'b1111111;

  logic                   clock, reset, flush;
  logic                   disp_valid, disp_ready;
  logic [TAG_W-1:0]       disp_rob;
  logic [6:0]             disp_op;
  logic [2:0]             disp_sub;
  logic                   disp_flag;
  logic [XLEN-1:0]        disp_data1, disp_data2;
  logic                   disp_q1_busy, disp_q2_busy;
  logic [TAG_W-1:0]       disp_q1, disp_q2;
  logic [N_CDB-1:0]       cdb_valid;
  logic [N_CDB*TAG_W-1:0] cdb_rob;
  logic [N_CDB*XLEN-1:0]  cdb_data;
  logic                   out_valid, out_ready;
  logic [TAG_W-1:0]       out_rob;
  logic [XLEN-1:0]        out_data;
  logic [2:0]             free_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_rs_param #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .N_CDB(N_CDB)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob(disp_rob),
    .disp_op(disp_op), .disp_sub(disp_sub), .disp_flag(disp_flag),
    .disp_data1(disp_data1), .disp_data2(disp_data2),
    .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
    .out_data(out_data), .free_count(free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_disp(input logic [5:0] rob, input logic [6:0] op, input logic [2:0] sub,
                          input logic flag, input logic [31:0] d1, input logic [31:0] d2,
                          input logic q1b, input logic [5:0] q1, input logic q2b,
                          input logic [5:0] q2);
    disp_valid = 1'b1; disp_rob = rob; disp_op = op; disp_sub = sub; disp_flag = flag;
    disp_data1 = d1; disp_data2 = d2;
    disp_q1_busy = q1b; disp_q1 = q1; disp_q2_busy = q2b; disp_q2 = q2;
  endtask

  task automatic clear_in();
    disp_valid = 1'b0; disp_rob = '0; disp_op = '0; disp_sub = '0; disp_flag = 1'b0;
    disp_data1 = '0; disp_data2 = '0; disp_q1_busy = 1'b0; disp_q2_busy = 1'b0;
    disp_q1 = '0; disp_q2 = '0;
    cdb_valid = '0; cdb_rob = '0; cdb_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; clear_in();
    step(); step();
    reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_rob !== 6'd0) begin n_fail++; $display("FAIL reset_out_rob: got %0d want 0", out_rob); end
    n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL reset_free_count: got %0d want 4", free_count); end
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %0b want 1", disp_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_disp(6'd5, CALC, 3'b000, 1'b1, 32'd10, 32'd3, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
    clear_in();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
    n_checks++; if (free_count !== 3'd3) begin n_fail++; $display("FAIL basic_free_after_disp: got %0d want 3", free_count); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    n_checks++; if (out_rob !== 6'd5) begin n_fail++; $display("FAIL basic_rob: got %0d want 5", out_rob); end
    n_checks++; if (out_data !== 32'd7) begin n_fail++; $display("FAIL basic_data: got %0h want 7", out_data); end
    n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL basic_free_after_issue: got %0d want 4", free_count); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b want 0", out_valid); end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  sub;
    logic        flag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v[13];
    logic q1b, q2b;
    v[0]  = '{CALC,  3'b000, 1'b0, 32'd100,       32'd23,        32'd123};
    v[1]  = '{CALC,  3'b001, 1'b0, 32'd1,         32'h24,        32'h10};
    v[2]  = '{CALC,  3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd1};
    v[3]  = '{CALC,  3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0};
    v[4]  = '{CALC,  3'b100, 1'b0, 32'hF0F0,      32'h0FF0,      32'hFF00};
    v[5]  = '{CALC,  3'b110, 1'b0, 32'hF0F0,      32'h0FF0,      32'hFFF0};
    v[6]  = '{CALC,  3'b111, 1'b0, 32'hF0F0,      32'h0FF0,      32'h00F0};
    v[7]  = '{CALC,  3'b101, 1'b0, 32'h8000_0000, 32'd4,         32'h0800_0000};
    v[8]  = '{CALC,  3'b101, 1'b1, 32'h8000_0000, 32'd4,         32'hF800_0000};
    v[9]  = '{CIMM,  3'b000, 1'b1, 32'd10,        32'd3,         32'd13};
    v[10] = '{LUI,   3'b000, 1'b0, 32'd999,       32'h1234_5000, 32'h1234_5000};
    v[11] = '{AUIPC, 3'b000, 1'b0, 32'd7,         32'hABC,       32'hABC};
    v[12] = '{BADOP, 3'b000, 1'b0, 32'd5,         32'd5,         32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      // busy flags that dispatch must ignore for this opcode class
      q1b = (v[i].op == LUI || v[i].op == AUIPC);
      q2b = (v[i].op == CIMM || v[i].op == LUI || v[i].op == AUIPC);
      set_disp(6'(16 + i), v[i].op, v[i].sub, v[i].flag, v[i].a, v[i].b, q1b, 6'd33, q2b, 6'd34);
      step();
      clear_in();
      step();
      n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'(16 + i) || out_data !== v[i].exp) begin
        n_fail++;
        $display("FAIL alu_vec%0d: got v=%0b rob=%0d data=%0h want v=1 rob=%0d data=%0h",
                 i, out_valid, out_rob, out_data, 16 + i, v[i].exp);
      end
      step();
    end
  endtask

  task automatic test_wake();
    out_ready = 1'b1;
    set_disp(6'd12, CIMM, 3'b101, 1'b1, 32'd0, 32'd4, 1'b1, 6'd9, 1'b0, 6'd0);
    step();
    clear_in();
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wake_not_ready: got %0b want 0", out_valid); end
    cdb_valid = 2'b10; cdb_rob[6 +: 6] = 6'd9; cdb_data[32 +: 32] = 32'hFFFF_FFF0;
    step();
    clear_in();
    if (!BYP) step();
    n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd12 || out_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wake_sra: got v=%0b rob=%0d data=%0h want v=1 rob=12 data=ffffffff", out_valid, out_rob, out_data);
    end
    step();
    // both channels hit the same tag: channel 0 must be the one captured
    set_disp(6'd13, CALC, 3'b000, 1'b0, 32'd0, 32'd1, 1'b1, 6'd20, 1'b0, 6'd0);
    step();
    clear_in();
    cdb_valid = 2'b11; cdb_rob[0 +: 6] = 6'd20; cdb_rob[6 +: 6] = 6'd20;
    cdb_data[0 +: 32] = 32'd100; cdb_data[32 +: 32] = 32'd200;
    step();
    clear_in();
    if (!BYP) step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd101) begin
      n_fail++; $display("FAIL wake_lowest_channel: got v=%0b data=%0d want v=1 data=101", out_valid, out_data);
    end
    step();
  endtask

  task automatic test_age();
    out_ready = 1'b1;
    set_disp(6'd1, CALC, 3'b000, 1'b0, 32'd0, 32'd1, 1'b1, 6'd3, 1'b0, 6'd0);
    step();
    set_disp(6'd2, CALC, 3'b000, 1'b0, 32'd2, 32'd2, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
    clear_in();
    step();
    n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd2 || out_data !== 32'd4) begin
      n_fail++; $display("FAIL age_ready_first: got v=%0b rob=%0d data=%0d want v=1 rob=2 data=4", out_valid, out_rob, out_data);
    end
    cdb_valid = 2'b01; cdb_rob[0 +: 6] = 6'd3; cdb_data[0 +: 32] = 32'd5;
    step();
    clear_in();
    if (!BYP) step();
    n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd1 || out_data !== 32'd6) begin
      n_fail++; $display("FAIL age_woken_second: got v=%0b rob=%0d data=%0d want v=1 rob=1 data=6", out_valid, out_rob, out_data);
    end
    step();
    // older entry lands in the higher index; both become ready together
    set_disp(6'd21, CALC, 3'b000, 1'b0, 32'd1, 32'd1, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
    set_disp(6'd22, CALC, 3'b000, 1'b0, 32'd0, 32'd10, 1'b1, 6'd4, 1'b0, 6'd0);
    step();
    n_checks++; if (out_rob !== 6'd21 || out_data !== 32'd2) begin
      n_fail++; $display("FAIL age_filler: got rob=%0d data=%0d want rob=21 data=2", out_rob, out_data);
    end
    set_disp(6'd23, CALC, 3'b000, 1'b0, 32'd0, 32'd20, 1'b1, 6'd4, 1'b0, 6'd0);
    step();
    clear_in();
    cdb_valid = 2'b01; cdb_rob[0 +: 6] = 6'd4; cdb_data[0 +: 32] = 32'd1;
    step();
    clear_in();
    if (!BYP) step();
    n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd22 || out_data !== 32'd11) begin
      n_fail++; $display("FAIL age_oldest_first: got v=%0b rob=%0d data=%0d want v=1 rob=22 data=11", out_valid, out_rob, out_data);
    end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd23 || out_data !== 32'd21) begin
      n_fail++; $display("FAIL age_younger_next: got v=%0b rob=%0d data=%0d want v=1 rob=23 data=21", out_valid, out_rob, out_data);
    end
    step();
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_disp(6'(31 + i), CALC, 3'b000, 1'b0, 32'(31 + i), 32'd100, 1'b0, 6'd0, 1'b0, 6'd0);
      step();
    end
    set_disp(6'd36, CALC, 3'b000, 1'b0, 32'd36, 32'd100, 1'b0, 6'd0, 1'b0, 6'd0);
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_disp_ready: got %0b want 0", disp_ready); end
    n_checks++; if (free_count !== 3'd0) begin n_fail++; $display("FAIL full_free_count: got %0d want 0", free_count); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd31 || out_data !== 32'd131 || free_count !== 3'd0) begin
        n_fail++; $display("FAIL full_hold%0d: got v=%0b rob=%0d data=%0d free=%0d want v=1 rob=31 data=131 free=0",
                           c, out_valid, out_rob, out_data, free_count);
      end
    end
    clear_in();
    out_ready = 1'b1;
    #1;
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_same_cycle: got %0b want 0", disp_ready); end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'(31 + i) || out_data !== 32'(131 + i) || free_count !== 3'(i)) begin
        n_fail++; $display("FAIL full_drain%0d: got v=%0b rob=%0d data=%0d free=%0d want v=1 rob=%0d data=%0d free=%0d",
                           i, out_valid, out_rob, out_data, free_count, 31 + i, 131 + i, i);
      end
    end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_disp(6'd40, CALC, 3'b000, 1'b0, 32'd1, 32'd1, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
    for (int i = 1; i <= 3; i++) begin
      set_disp(6'(40 + i), CALC, 3'b000, 1'b0, 32'd0, 32'd1, 1'b1, 6'd50, 1'b0, 6'd0);
      step();
    end
    n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd40 || free_count !== 3'd1) begin
      n_fail++; $display("FAIL flush_setup: got v=%0b rob=%0d free=%0d want v=1 rob=40 free=1", out_valid, out_rob, free_count);
    end
    flush = 1'b1;
    set_disp(6'd44, CALC, 3'b000, 1'b0, 32'd1, 32'd1, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
    flush = 1'b0;
    clear_in();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL flush_free_count: got %0d want 4", free_count); end
    out_ready = 1'b1;
    cdb_valid = 2'b01; cdb_rob[0 +: 6] = 6'd50; cdb_data[0 +: 32] = 32'd9;
    step();
    clear_in();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_output%0d: got %0b want 0", c, out_valid); end
      step();
    end
  endtask

  task automatic test_disp_bypass();
    out_ready = 1'b1;
    set_disp(6'd60, CALC, 3'b000, 1'b0, 32'd1, 32'd0, 1'b0, 6'd0, 1'b1, 6'd7);
    cdb_valid = 2'b01; cdb_rob[0 +: 6] = 6'd7; cdb_data[0 +: 32] = 32'd42;
    step();
    clear_in();
    step();
    n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd60 || out_data !== 32'd43) begin
      n_fail++; $display("FAIL disp_bypass: got v=%0b rob=%0d data=%0d want v=1 rob=60 data=43", out_valid, out_rob, out_data);
    end
    step();
  endtask

  task automatic test_reset_busy();
    out_ready = 1'b0;
    set_disp(6'd50, CALC, 3'b000, 1'b0, 32'd3, 32'd4, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
    set_disp(6'd51, CALC, 3'b000, 1'b0, 32'd0, 32'd4, 1'b1, 6'd2, 1'b0, 6'd0);
    step();
    clear_in();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin
      n_fail++; $display("FAIL rst_setup: got v=%0b data=%0d want v=1 data=7", out_valid, out_data);
    end
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_rob !== 6'd0 || out_data !== 32'd0 || free_count !== 3'd4) begin
      n_fail++; $display("FAIL rst_busy: got v=%0b rob=%0d data=%0h free=%0d want v=0 rob=0 data=0 free=4",
                         out_valid, out_rob, out_data, free_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu_ops();
    test_wake();
    test_age();
    test_full();
    test_flush();
    test_disp_bypass();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
